framebuffer_arbiter: RTL
========================

FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

Interface
REQ-001 Parameter ADDR_LEN, default 17, framebuffer read address width.
REQ-002 Parameter WIDTH, default 4, pixel data width.
REQ-003 Parameter READ_LATENCY, default 2, cycles from read_addr_out to valid read_data_in.
REQ-004 clk_in  input  1  sole clock; all state on rising edge.
REQ-005 rst_in  input  1  asynchronous, active-low reset.
REQ-006 vga_addr_in  input  ADDR_LEN  VGA display read address.
REQ-007 vga_blank_in  input  1  high during VGA vertical blanking.
REQ-008 eth_req_in  input  1  single-cycle export request pulse.
REQ-009 eth_addr_in  input  ADDR_LEN  ethernet export read address.
REQ-010 eth_done_in  input  1  single-cycle export-finished pulse.
REQ-011 swap_req_in  input  1  renderer new-frame pulse.
REQ-012 read_data_in  input  WIDTH  framebuffer read data.
REQ-013 read_addr_out  output  ADDR_LEN  framebuffer read address.
REQ-014 vga_data_out  output  WIDTH  pixel data routed to VGA display.
REQ-015 eth_data_out  output  WIDTH  pixel data routed to ethernet export.
REQ-016 eth_grant_out  output  1  ethernet owns read port.
REQ-017 swap_out  output  1  single-cycle buffer-swap pulse to BRAM manager.
REQ-018 deferred_count_out  output  8  saturating count of swap requests coalesced away.

Function
REQ-019 FSM states IDLE, WAIT_BLANK, GRANT, RELEASE.
REQ-020 IDLE: eth_req_in=1 -> WAIT_BLANK next cycle; otherwise stay.
REQ-021 WAIT_BLANK: vga_blank_in=1 -> GRANT next cycle; otherwise stay.
REQ-022 GRANT: eth_done_in=1 -> RELEASE next cycle; otherwise stay, no timeout.
REQ-023 RELEASE: always -> IDLE next cycle, lasts exactly one cycle.
REQ-024 eth_req_in outside IDLE ignored; eth_done_in outside GRANT ignored.
REQ-025 eth_grant_out = 1 exactly while state is GRANT (registered state decode).
REQ-026 read_addr_out = eth_addr_in in GRANT, else vga_addr_in (combinational from state register).
REQ-027 Owner bit (1 = ethernet, i.e. state GRANT) delayed through READ_LATENCY-stage shift register, reset 0.
REQ-028 Delayed owner=1: eth_data_out = read_data_in, vga_data_out = 0.
REQ-029 Delayed owner=0: vga_data_out = read_data_in, eth_data_out = 0.
REQ-030 swap_req_in in IDLE or WAIT_BLANK -> swap_out=1 on next cycle only.
REQ-031 swap_req_in in GRANT -> set swap_pending; no swap_out while in GRANT.
REQ-032 Each swap_req_in while swap_pending already set -> deferred_count_out +1, saturating at 255.
REQ-033 RELEASE with swap_pending set or swap_req_in=1 -> swap_out=1 on following cycle, exactly one pulse; swap_pending cleared.
REQ-034 swap_req_in in RELEASE while swap_pending already set -> counted per REQ-032.
REQ-035 eth_req_in and swap_req_in same cycle in IDLE -> swap passes per REQ-030 and FSM -> WAIT_BLANK.
REQ-036 eth_done_in and swap_req_in same cycle in GRANT -> request deferred, issued per REQ-033.
REQ-037 deferred_count_out never clears except on reset.

Reset
REQ-038 rst_in=0 asynchronously forces: state IDLE, swap_pending 0, owner pipe 0, eth_grant_out 0, swap_out 0, deferred_count_out 0.
REQ-039 Reset mid-GRANT drops grant immediately; pending swap discarded; no swap_out after release of reset.
REQ-040 During reset read_addr_out = vga_addr_in, eth_data_out = 0.

Verification
REQ-041 Reset, vga_addr_in=0x00123 -> read_addr_out=0x00123, all other outputs 0.
REQ-042 eth_req_in pulse, vga_blank_in=0 for 10 cycles then 1 -> eth_grant_out rises 1 cycle after blank high; read_addr_out follows eth_addr_in; eth_data_out carries read_data_in starting READ_LATENCY cycles after grant, vga_data_out=0 then.
REQ-043 During GRANT, three swap_req_in pulses, then eth_done_in -> no swap_out in GRANT, one swap_out pulse 2 cycles after eth_done_in, deferred_count_out=2.
REQ-044 swap_req_in in IDLE -> swap_out high exactly one cycle, next cycle; eth_req_in in GRANT ignored (grant stays, no re-arm after RELEASE).
REQ-045 300 swap_req_in pulses during single GRANT -> deferred_count_out=255.
REQ-046 rst_in low mid-GRANT with swap pending -> eth_grant_out 0 without clock edge; after reset release no swap_out pulse.

Source files
------------

// File: rtl/framebuffer_arbiter.sv
// Shares one framebuffer read port between VGA scan-out and ethernet export;
// ethernet is granted only during vertical blanking, and buffer swaps are deferred while it owns the port.
module framebuffer_arbiter #(
    parameter int unsigned ADDR_LEN     = 17,
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [ADDR_LEN-1:0] vga_addr_in,
    input  logic                vga_blank_in,
    input  logic                eth_req_in,
    input  logic [ADDR_LEN-1:0] eth_addr_in,
    input  logic                eth_done_in,
    input  logic                swap_req_in,
    input  logic [WIDTH-1:0]    read_data_in,
    output logic [ADDR_LEN-1:0] read_addr_out,
    output logic [WIDTH-1:0]    vga_data_out,
    output logic [WIDTH-1:0]    eth_data_out,
    output logic                eth_grant_out,
    output logic                swap_out,
    output logic [7:0]          deferred_count_out
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BLANK = 2'd1,
        GRANT      = 2'd2,
        RELEASE    = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic                    swap_pending, pending_nxt;
    logic                    swap_nxt;
    logic                    grant_nxt;
    logic [CNT_W-1:0]        dcnt_nxt;
    logic [READ_LATENCY-1:0] owner_pipe;
    logic                    owner_d;

    // State, swap bookkeeping and registered outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state              <= IDLE;
            swap_pending       <= 1'b0;
            swap_out           <= 1'b0;
            eth_grant_out      <= 1'b0;
            deferred_count_out <= '0;
        end else begin
            state              <= state_nxt;
            swap_pending       <= pending_nxt;
            swap_out           <= swap_nxt;
            eth_grant_out      <= grant_nxt;
            deferred_count_out <= dcnt_nxt;
        end
    end

    // Next-state, swap deferral and saturating coalesce counter
    always_comb begin
        state_nxt   = state;
        pending_nxt = swap_pending;
        swap_nxt    = 1'b0;
        dcnt_nxt    = deferred_count_out;

        case (state)
            IDLE: begin
                if (eth_req_in) state_nxt = WAIT_BLANK;
                if (swap_req_in) swap_nxt = 1'b1;
            end
            WAIT_BLANK: begin
                if (vga_blank_in) state_nxt = GRANT;
                if (swap_req_in) swap_nxt = 1'b1;
            end
            GRANT: begin
                if (eth_done_in) state_nxt = RELEASE;
                if (swap_req_in) pending_nxt = 1'b1;
            end
            RELEASE: begin
                state_nxt   = IDLE;
                swap_nxt    = swap_pending | swap_req_in;
                pending_nxt = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase

        // A request arriving while one is already held is coalesced away
        if (swap_req_in && swap_pending && (deferred_count_out != CNT_MAX))
            dcnt_nxt = deferred_count_out + CNT_W'(1);

        grant_nxt = (state_nxt == GRANT);
    end

    // Owner bit tracks which requester the in-flight read data belongs to
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            owner_pipe <= '0;
        end else begin
            owner_pipe[0] <= (state == GRANT);
            for (int i = 1; i < int'(READ_LATENCY); i++)
                owner_pipe[i] <= owner_pipe[i-1];
        end
    end

    assign owner_d       = owner_pipe[READ_LATENCY-1];
    assign read_addr_out = (state == GRANT) ? eth_addr_in : vga_addr_in;
    assign eth_data_out  = owner_d ? read_data_in : '0;
    assign vga_data_out  = owner_d ? '0 : read_data_in;

endmodule
